voice_mixer_pwm: RTL and testbench
==================================

# voice_mixer_pwm

Downstream audio back end for the piano: sums the signed amplitude outputs of VOICES parallel note generators, applies a master gain, saturates, and drives a single-bit PWM audio pin. Computes one mixed sample per PWM frame with a small sequential accumulator. Duty is double-buffered so a frame never changes mid-period.

## Interface
- CLK_FREQ, 120_000_000, system clock frequency in Hz; informational. Frame rate is CLK_FREQ / 2^PWM_BITS.
- AM_WIDTH, 8, width of each signed voice amplitude.
- VOICES, 4, number of voice inputs; must be ≥ 1.
- PWM_BITS, 10, PWM counter and sample width. Must satisfy PWM_BITS ≥ AM_WIDTH and VOICES+4 < 2^PWM_BITS.
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- am_bus  in  VOICES*AM_WIDTH  packed signed amplitudes; voice i at [i*AM_WIDTH +: AM_WIDTH].
- voice_en  in  VOICES  per-voice enable; a disabled voice contributes 0.
- volume  in  8  unsigned master gain; gain = volume/64, so 64 is unity and 255 ≈ 3.98.
- clip_clr  in  1  synchronous clear of the sticky clip flag.
- pwm_out  out  1  registered PWM output.
- sample  out  PWM_BITS  last computed unsigned sample, offset-binary.
- sample_valid  out  1  one-cycle pulse when sample updates.
- clip  out  1  sticky; set when saturation occurs.

## Operation
- cnt: a PWM_BITS-bit counter, free-running, wrapping from 2^PWM_BITS−1 to 0.
- Mixer FSM states: IDLE, ACC, SCALE, CLIP, PUBLISH.
  - IDLE, cnt==0: snapshot am_bus, voice_en and volume into holding registers. Clear acc. Go to ACC.
  - ACC: adds one voice per cycle, in order 0..VOICES−1. An enabled voice adds its sign-extended value; a disabled voice adds 0. acc width is AM_WIDTH+clog2(VOICES)+1, so it never overflows. After VOICES cycles, go to SCALE.
  - SCALE: prod = acc × {0,volume}, signed; then scaled = prod >>> 6. The shift is arithmetic and rounds toward −∞.
  - CLIP: clamp scaled to [−2^(PWM_BITS−1), 2^(PWM_BITS−1)−1]. If clamping occurred, set clip. duty_next = clamped + 2^(PWM_BITS−1), giving the range 0..2^PWM_BITS−1.
  - PUBLISH: sample ← duty_next; pulse sample_valid; return to IDLE.
- At cnt == 2^PWM_BITS−1: duty ← duty_next, the double-buffer commit.
- pwm_out ← (cnt < duty), registered.
  - duty 0 gives a constant low output.
  - duty 2^PWM_BITS−1 gives high for all but one cycle per frame.
- Input changes outside the cnt==0 snapshot cycle have no effect on the current sample.
- clip_clr and a new clip event in the same cycle: clip stays 1, set wins.
- Reset values:
  - cnt 0, state IDLE, acc 0, clip 0, sample_valid 0, pwm_out 0.
  - duty, duty_next and sample all 2^(PWM_BITS−1), i.e. silence.

## Timing
- Frame length is 2^PWM_BITS cycles; with the defaults that is 1024 cycles, about 117 kHz.
- Snapshot is taken in the cycle cnt==0.
- ACC runs while cnt = 1..VOICES.
- SCALE at cnt = VOICES+1, CLIP at cnt = VOICES+2.
- PUBLISH and sample_valid at cnt = VOICES+3; this is cnt = 7 for the defaults.
- The new duty is committed at the end of the same frame. It first affects pwm_out one cycle after cnt==0 of the next frame, because of the registered compare.
- Snapshot to first PWM edge: 2^PWM_BITS+1 cycles.
- The first frame after reset release uses midscale duty.
- Reset asserted at any point, including mid-ACC:
  - all state returns to reset values asynchronously;
  - no sample_valid is emitted for the aborted frame.

## Structure
- Shared package piano_audio_pkg holds:
  - the clog2 function;
  - the GAIN_SHIFT=6 constant;
  - a saturate(value, width) function;
  - the midscale constant function 2^(w−1).
- Sub-module pwm_gen contains the cnt counter, the duty double-buffer and the registered compare. It exports:
  - frame_start (cnt==0);
  - frame_end (cnt==max).

  The mixer FSM stays in voice_mixer_pwm and sequences off frame_start.

## Test plan
All scenarios use the default parameters.
1. Reset held low, then released → pwm_out=0, sample=512 and clip=0 during reset; the first frame after release has exactly 512 high cycles.
2. All voices 0, voice_en=4'hF, volume=64 → sample=512 and sample_valid exactly once per 1024 cycles, at cnt=7.
3. Voice0=+100, voice_en=4'b0001, others=+50, volume=64 → sample=612; the next frame has 612 high cycles.
4. Voice0=−101, voice_en=4'b0001, volume=32 → scaled=−51 (floor), sample=461.
5. All voices=+127, all enabled, volume=128 → scaled 1016 is clamped to 511, sample=1023, clip=1. clip_clr pulse with quiet input → clip=0. clip_clr coincident with a new clip → clip=1.
6. am_bus changed at cnt=3 of a frame → that frame's sample reflects the cnt==0 snapshot only. Reset asserted at cnt=2 → no sample_valid that frame, sample=512.

Source files
------------

// File: rtl/piano_audio_pkg.sv
// Shared audio helpers: clog2, gain shift, saturation, midscale, mixer states.
package piano_audio_pkg;

  localparam int unsigned GAIN_SHIFT = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC     = 3'd1,
    SCALE   = 3'd2,
    CLIP    = 3'd3,
    PUBLISH = 3'd4
  } mix_state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Offset-binary zero point 2^(w-1).
  function automatic int unsigned midscale(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // Clamp a signed value into a w-bit two's complement range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/voice_mixer_pwm_if.sv
// Mixer bus: voice amplitudes, enables, gain and clip control in; PWM and sample status out.
//   master: drives am_bus, voice_en, volume, clip_clr; observes pwm_out, sample, sample_valid, clip
//   slave : the mixer
interface voice_mixer_pwm_if #(
  parameter int unsigned AM_WIDTH = 8,
  parameter int unsigned VOICES   = 4,
  parameter int unsigned PWM_BITS = 10
);
  logic [VOICES*AM_WIDTH-1:0] am_bus;
  logic [VOICES-1:0]          voice_en;
  logic [7:0]                 volume;
  logic                       clip_clr;
  logic                       pwm_out;
  logic [PWM_BITS-1:0]        sample;
  logic                       sample_valid;
  logic                       clip;

  modport master (
    output am_bus, voice_en, volume, clip_clr,
    input  pwm_out, sample, sample_valid, clip
  );

  modport slave (
    input  am_bus, voice_en, volume, clip_clr,
    output pwm_out, sample, sample_valid, clip
  );
endinterface

// File: rtl/voice_mixer_pwm_pwm_gen.sv
// PWM generator: free-running frame counter, double-buffered duty, registered compare.
//   clk, rst       : clock, async active-low reset
//   duty_next      : duty to commit at the end of the current frame
//   frame_start    : high while cnt == 0
//   frame_end      : high while cnt == 2^PWM_BITS-1
//   pwm_out        : registered (cnt < duty)
module pwm_gen
  import piano_audio_pkg::*;
#(
  parameter int unsigned PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_next,
  output logic                frame_start,
  output logic                frame_end,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [PWM_BITS-1:0] MID     = PWM_BITS'(midscale(PWM_BITS));

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;

  // Frame flags are registered one count early so they line up with cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      duty        <= MID;
      pwm_out     <= 1'b0;
      frame_start <= 1'b1;
      frame_end   <= 1'b0;
    end else begin
      cnt         <= cnt + PWM_BITS'(1);
      frame_start <= (cnt == CNT_MAX);
      frame_end   <= (cnt == CNT_MAX - PWM_BITS'(1));
      pwm_out     <= (cnt < duty);
      if (frame_end) duty <= duty_next;
    end
  end

endmodule

// File: rtl/voice_mixer_pwm.sv
// Voice mixer with PWM output: snapshot voices at frame start, accumulate one voice per
// cycle, apply volume/64 gain, saturate, and hand the offset-binary duty to pwm_gen.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of voice_mixer_pwm_if (amplitudes, enables, volume, clip_clr in;
//              pwm_out, sample, sample_valid, sticky clip out)
module voice_mixer_pwm
  import piano_audio_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 120_000_000,
  parameter int unsigned AM_WIDTH = 8,
  parameter int unsigned VOICES   = 4,
  parameter int unsigned PWM_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  voice_mixer_pwm_if.slave bus
);

  localparam int unsigned ACC_W  = AM_WIDTH + clog2(VOICES) + 1;
  localparam int unsigned PROD_W = ACC_W + 9;
  localparam int unsigned IDX_W  = (VOICES > 1) ? clog2(VOICES) : 1;
  localparam logic [PWM_BITS-1:0]   MID   = PWM_BITS'(midscale(PWM_BITS));
  localparam logic signed [63:0]    MID64 = 64'(midscale(PWM_BITS));
  localparam logic [IDX_W-1:0]      LAST  = IDX_W'(VOICES - 1);

  mix_state_e                 state;
  logic [VOICES*AM_WIDTH-1:0] am_hold;
  logic [VOICES-1:0]          en_hold;
  logic [7:0]                 vol_hold;
  logic [IDX_W-1:0]           idx;
  logic signed [ACC_W-1:0]    acc;
  logic signed [PROD_W-1:0]   scaled;
  logic [PWM_BITS-1:0]        duty_next;
  logic                       frame_start;
  logic                       frame_end;

  logic signed [AM_WIDTH-1:0] voice_c;
  logic signed [ACC_W-1:0]    add_c;
  logic signed [PROD_W-1:0]   acc_ext_c;
  logic signed [PROD_W-1:0]   vol_ext_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [63:0]         scaled_ext_c;
  logic signed [63:0]         sat_c;
  logic                       clipped_c;
  logic [PWM_BITS-1:0]        duty_c;

  // Datapath: current voice term, gain product, saturation and offset.
  always_comb begin
    voice_c      = am_hold[idx*AM_WIDTH +: AM_WIDTH];
    add_c        = '0;
    if (en_hold[idx]) add_c = {{(ACC_W-AM_WIDTH){voice_c[AM_WIDTH-1]}}, voice_c};
    acc_ext_c    = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
    vol_ext_c    = {{(PROD_W-8){1'b0}}, vol_hold};
    prod_c       = acc_ext_c * vol_ext_c;
    scaled_ext_c = {{(64-PROD_W){scaled[PROD_W-1]}}, scaled};
    sat_c        = saturate(scaled_ext_c, PWM_BITS);
    clipped_c    = (sat_c != scaled_ext_c);
    duty_c       = PWM_BITS'(sat_c + MID64);
  end

  // Mixer sequencer; sample/sample_valid are loaded on the CLIP->PUBLISH edge so they
  // are visible during the PUBLISH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      am_hold          <= '0;
      en_hold          <= '0;
      vol_hold         <= '0;
      idx              <= '0;
      acc              <= '0;
      scaled           <= '0;
      duty_next        <= MID;
      bus.sample       <= MID;
      bus.sample_valid <= 1'b0;
      bus.clip         <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      if (bus.clip_clr) bus.clip <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            am_hold  <= bus.am_bus;
            en_hold  <= bus.voice_en;
            vol_hold <= bus.volume;
            acc      <= '0;
            idx      <= '0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= acc + add_c;
          if (idx == LAST) state <= SCALE;
          else             idx   <= idx + IDX_W'(1);
        end
        SCALE: begin
          scaled <= prod_c >>> GAIN_SHIFT;
          state  <= CLIP;
        end
        CLIP: begin
          duty_next        <= duty_c;
          bus.sample       <= duty_c;
          bus.sample_valid <= 1'b1;
          if (clipped_c) bus.clip <= 1'b1;
          state            <= PUBLISH;
        end
        PUBLISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_gen (
    .clk         (clk),
    .rst         (rst),
    .duty_next   (duty_next),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pwm_out     (bus.pwm_out)
  );

  // frame_end is consumed inside pwm_gen; kept here for frame-aligned debug taps.
  logic frame_end_unused;
  assign frame_end_unused = frame_end;

endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Directed bench for voice_mixer_pwm with default parameters.
module tb_voice_mixer_pwm;

  localparam int unsigned AM_WIDTH = 8;
  localparam int unsigned VOICES   = 4;
  localparam int unsigned PWM_BITS = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_mixer_pwm_if #(.AM_WIDTH(AM_WIDTH), .VOICES(VOICES), .PWM_BITS(PWM_BITS)) vif ();

  voice_mixer_pwm #(
    .CLK_FREQ (120_000_000),
    .AM_WIDTH (AM_WIDTH),
    .VOICES   (VOICES),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_voices(input int v0, input int v1, input int v2, input int v3,
                            input int en, input int vol);
    vif.am_bus   = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    vif.voice_en = 4'(en);
    vif.volume   = 8'(vol);
  endtask

  // Advance at least one cycle, then wait (bounded) for the next sample_valid.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!vif.sample_valid && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(vif.sample_valid), 1);
  endtask

  // Count pwm_out highs over 1024 consecutive cycles, noting any sample published meanwhile.
  task automatic count_frame(output int highs, output int vals, output int last_sample);
    highs = 0;
    vals = 0;
    last_sample = -1;
    for (int i = 0; i < 1024; i++) begin
      highs += int'(vif.pwm_out);
      if (vif.sample_valid) begin
        vals++;
        last_sample = int'(vif.sample);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int highs, vals, vpos, vs;

    // Reset with silent, fully enabled, unity-gain inputs.
    set_voices(0, 0, 0, 0, 4'hF, 64);
    vif.clip_clr = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(vif.pwm_out), 0);
    check("rst_sample", int'(vif.sample), 512);
    check("rst_clip", int'(vif.clip), 0);
    check("rst_valid", int'(vif.sample_valid), 0);

    // First frame: midscale duty, one sample_valid at cnt=7.
    rst = 1'b1;
    highs = 0; vals = 0; vpos = -1; vs = -1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      highs += int'(vif.pwm_out);
      if (vif.sample_valid) begin
        vals++;
        vpos = i + 1;
        vs = int'(vif.sample);
      end
    end
    check("f0_highs", highs, 512);
    check("f0_valid_count", vals, 1);
    check("f0_valid_cnt", vpos, 7);
    check("f0_sample", vs, 512);

    // Now in the cnt==0 cycle of frame 1: single enabled voice +100 at unity.
    set_voices(100, 50, 50, 50, 4'b0001, 64);
    wait_valid("t3_seen");
    check("t3_sample", int'(vif.sample), 612);

    // Queue the floor-rounding case, then measure the frame that carries 612.
    set_voices(-101, 0, 0, 0, 4'b0001, 32);
    repeat (1018) @(negedge clk);
    count_frame(highs, vals, vs);
    check("t3_highs", highs, 612);
    check("t4_valid_count", vals, 1);
    check("t4_sample", vs, 461);

    // Saturation: 4*127*128/64 = 1016 clamps to 511.
    wait_valid("t4b_seen");
    set_voices(127, 127, 127, 127, 4'hF, 128);
    wait_valid("t5_seen");
    check("t5_sample", int'(vif.sample), 1023);
    check("t5_clip_set", int'(vif.clip), 1);

    // clip_clr with quiet input clears the flag and it stays clear.
    set_voices(0, 0, 0, 0, 4'hF, 64);
    vif.clip_clr = 1'b1;
    @(negedge clk);
    vif.clip_clr = 1'b0;
    check("t5_clip_clr", int'(vif.clip), 0);
    wait_valid("t5q_seen");
    check("t5q_clip", int'(vif.clip), 0);
    check("t5q_sample", int'(vif.sample), 512);

    // clip_clr in the same cycle as a new clip event: set wins.
    set_voices(127, 127, 127, 127, 4'hF, 128);
    repeat (1023) @(negedge clk);
    check("t5c_clip_before", int'(vif.clip), 0);
    vif.clip_clr = 1'b1;
    @(negedge clk);
    vif.clip_clr = 1'b0;
    check("t5c_valid", int'(vif.sample_valid), 1);
    check("t5c_clip", int'(vif.clip), 1);
    check("t5c_sample", int'(vif.sample), 1023);

    // Input change at cnt=3 must not affect this frame's sample.
    set_voices(10, 0, 0, 0, 4'b0001, 64);
    repeat (1020) @(negedge clk);
    set_voices(90, 0, 0, 0, 4'b0001, 64);
    wait_valid("t6_seen");
    check("t6_snapshot", int'(vif.sample), 522);

    // Reset at cnt=2 of the next frame aborts it.
    repeat (1019) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6r_sample", int'(vif.sample), 512);
    check("t6r_pwm_out", int'(vif.pwm_out), 0);
    check("t6r_clip", int'(vif.clip), 0);
    vals = 0;
    for (int i = 0; i < 10; i++) begin
      vals += int'(vif.sample_valid);
      @(negedge clk);
    end
    check("t6r_no_valid", vals, 0);
    rst = 1'b1;
    wait_valid("t6p_seen");
    check("t6p_sample", int'(vif.sample), 602);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
